// File: rtl/led_pwm_driver_pkg.sv
// Shared types and helpers for the front-panel LED output stage.
// Lamp-test state encoding and width helper.
package led_pwm_driver_pkg;

    localparam int PWM_BITS_DEF = 8;

    typedef enum logic [1:0] {
        LAMP_IDLE,
        LAMP_WALK,
        LAMP_ALL_ON
    } lamp_state_t;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/led_pwm_driver_stretch.sv
// Single-LED edge detect and minimum on-time stretcher.
// A rising edge reloads the counter even while a stretch is running.
module led_stretch_cell
    import led_pwm_driver_pkg::*;
#(
    parameter int STRETCH_TICKS = 2048
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic led,
    output logic stretched
);

    localparam int CW = clog2(STRETCH_TICKS + 1);
    localparam logic [CW-1:0] LOAD = CW'(STRETCH_TICKS);

    logic          led_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            led_q <= 1'b0;
            cnt   <= '0;
        end else begin
            led_q <= led;
            if (led && !led_q) begin
                cnt <= LOAD;
            end else if (tick && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign stretched = led_q | (cnt != '0);

endmodule

// File: rtl/led_pwm_driver.sv
// Front-panel LED driver: global PWM dimming, flash stretching
// and a lamp-test walk, all in the fabric clock domain.
module led_pwm_driver
    import led_pwm_driver_pkg::*;
#(
    parameter int NLEDS         = 16,
    parameter int PWM_BITS      = PWM_BITS_DEF,
    parameter int PRESCALE      = 16,
    parameter int STRETCH_TICKS = 2048,
    parameter int LAMP_DWELL    = 4096
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NLEDS-1:0]    led_i,
    input  logic [PWM_BITS-1:0] brightness_i,
    input  logic                lamp_test_i,
    output logic [NLEDS-1:0]    led_o,
    output logic                lamp_busy_o
);

    localparam int PSW  = clog2(PRESCALE);
    localparam int IDXW = clog2(NLEDS);
    localparam int DWW  = clog2(4 * LAMP_DWELL);

    localparam logic [PSW-1:0]  PS_LAST   = PSW'(PRESCALE - 1);
    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NLEDS - 1);
    localparam logic [DWW-1:0]  WALK_LAST = DWW'(LAMP_DWELL - 1);
    localparam logic [DWW-1:0]  ALL_LAST  = DWW'(4 * LAMP_DWELL - 1);
    localparam logic [NLEDS-1:0] ONE_HOT0 = NLEDS'(1);

    logic [PSW-1:0]      presc;
    logic                tick;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] brightness_q;
    logic                pwm_on;
    logic [NLEDS-1:0]    stretched;

    lamp_state_t         state, state_n;
    logic [IDXW-1:0]     idx, idx_n;
    logic [DWW-1:0]      dwell, dwell_n;
    logic [NLEDS-1:0]    led_n;

    assign tick = (presc == PS_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            presc <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    // Brightness is only sampled at the period boundary to avoid glitches.
    always_ff @(posedge clock) begin
        if (reset) begin
            pwm_cnt      <= '0;
            brightness_q <= '1;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (&pwm_cnt) brightness_q <= brightness_i;
        end
    end

    assign pwm_on = (&brightness_q) | (pwm_cnt < brightness_q);

    for (genvar g = 0; g < NLEDS; g++) begin : g_cell
        led_stretch_cell #(
            .STRETCH_TICKS(STRETCH_TICKS)
        ) u_cell (
            .clock    (clock),
            .reset    (reset),
            .tick     (tick),
            .led      (led_i[g]),
            .stretched(stretched[g])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= LAMP_IDLE;
            idx         <= '0;
            dwell       <= '0;
            led_o       <= '0;
            lamp_busy_o <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            dwell       <= dwell_n;
            led_o       <= led_n;
            lamp_busy_o <= (state_n != LAMP_IDLE);
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        dwell_n = dwell;
        unique case (state)
            LAMP_IDLE: begin
                if (lamp_test_i) begin
                    state_n = LAMP_WALK;
                    idx_n   = '0;
                    dwell_n = '0;
                end
            end
            LAMP_WALK: begin
                if (tick) begin
                    if (dwell == WALK_LAST) begin
                        dwell_n = '0;
                        if (idx == IDX_LAST) state_n = LAMP_ALL_ON;
                        else idx_n = idx + 1'b1;
                    end else begin
                        dwell_n = dwell + 1'b1;
                    end
                end
            end
            LAMP_ALL_ON: begin
                if (tick) begin
                    if (dwell == ALL_LAST) begin
                        dwell_n = '0;
                        state_n = LAMP_IDLE;
                    end else begin
                        dwell_n = dwell + 1'b1;
                    end
                end
            end
            default: state_n = LAMP_IDLE;
        endcase

        // Output follows the next state so it lines up with lamp_busy_o.
        led_n = stretched & {NLEDS{pwm_on}};
        case (state_n)
            LAMP_WALK:   led_n = ONE_HOT0 << idx_n;
            LAMP_ALL_ON: led_n = '1;
            default:     ;
        endcase
    end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed self-checking bench for led_pwm_driver.
// Small parameters keep PWM periods and lamp walk short.
module tb_led_pwm_driver;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] led_i;
    logic [3:0]  brightness_i;
    logic        lamp_test_i;
    logic [15:0] led_o;
    logic        lamp_busy_o;

    int n_chk  = 0;
    int n_pass = 0;

    led_pwm_driver #(
        .NLEDS        (16),
        .PWM_BITS     (4),
        .PRESCALE     (2),
        .STRETCH_TICKS(4),
        .LAMP_DWELL   (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .led_i       (led_i),
        .brightness_i(brightness_i),
        .lamp_test_i (lamp_test_i),
        .led_o       (led_o),
        .lamp_busy_o (lamp_busy_o)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim did not finish");
        $fatal(1);
    end

    initial begin
        int hi;
        int bad;
        int cyc;
        int stage;
        int run;
        int seq_err;
        int len_err;
        logic [15:0] prev;
        logic [31:0] exp_v;

        reset        = 1'b1;
        led_i        = '0;
        brightness_i = 4'd15;
        lamp_test_i  = 1'b0;
        repeat (3) step();
        check("rst_led", led_o, 0);
        check("rst_busy", lamp_busy_o, 0);

        reset = 1'b0;
        led_i = 16'h00FF;
        step();
        check("lat_1cyc", led_o, 0);
        step();
        check("lat_2cyc", led_o, 16'h00FF);
        bad = 0;
        repeat (40) begin
            step();
            if (led_o != 16'h00FF) bad++;
        end
        check("steady_00ff", bad, 0);

        led_i = '0;
        repeat (20) step();
        led_i = 16'h0008;
        step();
        led_i = '0;
        hi = 0;
        repeat (20) begin
            step();
            hi += int'(led_o[3]);
        end
        check("stretch_one", (hi == 7 || hi == 8), 1);

        repeat (20) step();
        led_i = 16'h0008;
        step();
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            led_i = (i == 3) ? 16'h0008 : 16'h0000;
            step();
            hi += int'(led_o[3]);
        end
        led_i = '0;
        check("stretch_reload", (hi == 11 || hi == 12), 1);

        led_i = 16'h0F0F;
        repeat (40) step();
        lamp_test_i = 1'b1;
        step();
        lamp_test_i = 1'b0;
        check("lamp_busy_rise", lamp_busy_o, 1);
        check("walk_first", led_o, 16'h0001);
        stage   = 0;
        run     = 1;
        seq_err = 0;
        len_err = 0;
        cyc     = 0;
        prev    = led_o;
        while (lamp_busy_o && cyc < 300) begin
            lamp_test_i = (cyc == 20);
            step();
            cyc++;
            if (!lamp_busy_o) break;
            if (led_o == prev) begin
                run++;
            end else begin
                if (stage >= 1 && run != 6) len_err++;
                stage++;
                exp_v = (stage < 16) ? (32'd1 << stage) : 32'hFFFF;
                if (stage > 16 || led_o != exp_v[15:0]) seq_err++;
                prev = led_o;
                run  = 1;
            end
        end
        lamp_test_i = 1'b0;
        check("lamp_timeout", (cyc < 300), 1);
        check("walk_order", seq_err, 0);
        check("walk_dwell", len_err, 0);
        check("walk_stages", stage, 16);
        check("all_on_len", run, 24);
        check("lamp_busy_fall", lamp_busy_o, 0);
        check("lamp_resume", led_o, 16'h0F0F);

        lamp_test_i = 1'b1;
        step();
        lamp_test_i = 1'b0;
        cyc = 0;
        while (led_o != 16'h0020 && cyc < 200) begin
            step();
            cyc++;
        end
        check("walk_idx5", led_o, 16'h0020);
        reset        = 1'b1;
        brightness_i = 4'd4;
        led_i        = 16'h0001;
        step();
        check("rst_walk_led", led_o, 0);
        check("rst_walk_busy", lamp_busy_o, 0);
        reset = 1'b0;
        hi = 0;
        repeat (32) begin
            step();
            hi += int'(led_o[0]);
        end
        check("bq_defer_full", hi, 31);
        hi = 0;
        repeat (32) begin
            step();
            hi += int'(led_o[0]);
        end
        check("duty_4of16", hi, 8);

        brightness_i = 4'd0;
        led_i        = 16'hFFFF;
        repeat (40) step();
        bad = 0;
        repeat (32) begin
            step();
            if (led_o != 16'h0000) bad++;
        end
        check("bright0_off", bad, 0);

        brightness_i = 4'd15;
        repeat (40) step();
        bad = 0;
        repeat (32) begin
            step();
            if (led_o != 16'hFFFF) bad++;
        end
        check("bright15_full", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
